// File: rtl/uart_word_rx.sv
// rtl/uart_word_rx.sv - 8N1 UART receiver packing four bytes, first byte in the MSB, into 32-bit words
// Optional partial-word idle timeout is enabled by defining UART_RX_TIMEOUT_EN.
module uart_word_rx #(
  parameter int CLK_FREQ     = 100000000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic        sysclk,
  input  logic        rst,
  input  logic        RxSerial,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic        frame_err,
  output logic        busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rxs_q;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [31:0]   word_sr_q, word_sr_d;
  logic [7:0]    byte_data_q, byte_data_d;
  logic [31:0]   word_data_q, word_data_d;
  logic          byte_valid_q, byte_valid_d;
  logic          word_valid_q, word_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [31:0]   word_next;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  assign word_next = {word_sr_q[23:0], shift_q};

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    word_sr_d    = word_sr_q;
    byte_data_d  = byte_data_q;
    word_data_d  = word_data_q;
    byte_valid_d = 1'b0;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d   = START;
          clk_cnt_d = '0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rxs_q ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_cnt_q] = rxs_q;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (clk_cnt_q == FULL_LAST) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (rxs_q) begin
            byte_data_d  = shift_q;
            byte_valid_d = 1'b1;
            word_sr_d    = word_next;
            byte_idx_d   = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              word_data_d  = word_next;
              word_valid_d = 1'b1;
            end
          end else begin
            // A framing error poisons the word being assembled.
            frame_err_d = 1'b1;
            byte_idx_d  = '0;
            word_sr_d   = '0;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_RX_TIMEOUT_EN
    idle_cnt_d = '0;
    if (state_q == IDLE && byte_idx_q != 2'd0 && rxs_q) begin
      if (idle_cnt_q == TIMEOUT_LAST) begin
        byte_idx_d = '0;
        word_sr_d  = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      rx_meta_q    <= 1'b1;
      rxs_q        <= 1'b1;
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_idx_q   <= '0;
      word_sr_q    <= '0;
      byte_data_q  <= '0;
      word_data_q  <= '0;
      byte_valid_q <= 1'b0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_TIMEOUT_EN
      idle_cnt_q   <= '0;
`endif
    end else begin
      rx_meta_q    <= RxSerial;
      rxs_q        <= rx_meta_q;
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      word_sr_q    <= word_sr_d;
      byte_data_q  <= byte_data_d;
      word_data_q  <= word_data_d;
      byte_valid_q <= byte_valid_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_TIMEOUT_EN
      idle_cnt_q   <= idle_cnt_d;
`endif
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_valid = byte_valid_q;
  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_word_rx.sv
// tb/tb_uart_word_rx.sv - directed/randomized bench for uart_word_rx against a byte/word queue model
module tb_uart_word_rx;
  localparam int CPB = 16;
  localparam int TOB = 16;

  logic        sysclk, rst, RxSerial;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [31:0] word_data;
  logic        word_valid, frame_err, busy;

  uart_word_rx #(.CLK_FREQ(1600), .BAUD(100), .TIMEOUT_BITS(TOB)) dut (
    .sysclk(sysclk), .rst(rst), .RxSerial(RxSerial),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .word_data(word_data), .word_valid(word_valid),
    .frame_err(frame_err), .busy(busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [7:0]  obs_bytes[$];
  logic [31:0] obs_words[$];
  int obs_fe = 0, pulse_viol = 0, bv_cyc = 0;
  logic prev_bv = 1'b0, prev_wv = 1'b0, prev_fe = 1'b0;

  always @(negedge sysclk) begin
    if (byte_valid) begin obs_bytes.push_back(byte_data); bv_cyc = cyc; end
    if (word_valid) obs_words.push_back(word_data);
    if (frame_err) obs_fe++;
    if ((byte_valid && prev_bv) || (word_valid && prev_wv) || (frame_err && prev_fe) ||
        (byte_valid && frame_err) || (word_valid && !byte_valid))
      pulse_viol++;
    prev_bv = byte_valid; prev_wv = word_valid; prev_fe = frame_err;
  end

  // Reference model: received bytes, completed words and the current partial word.
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_words[$];
  logic [7:0]  partial[$];
  logic [7:0]  last_byte = 8'h00;
  logic [31:0] last_word = 32'h0;
  int exp_fe = 0, fall_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    if (n > 0) begin
      repeat (n) @(posedge sysclk);
      #1;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_bytes.push_back(b);
    partial.push_back(b);
    last_byte = b;
    if (partial.size() == 4) begin
      last_word = {partial[0], partial[1], partial[2], partial[3]};
      exp_words.push_back(last_word);
      partial.delete();
    end
  endtask

  task automatic model_reset();
    partial.delete();
    last_byte = 8'h00;
    last_word = 32'h0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RxSerial = 1'b0;
    fall_cyc = cyc;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      RxSerial = b[i];
      wait_clks(CPB);
    end
    RxSerial = stop;
    wait_clks(CPB);
    RxSerial = 1'b1;
    if (stop) model_byte(b);
    else begin partial.delete(); exp_fe++; end
  endtask

  task automatic idle_bits(input int n);
    RxSerial = 1'b1;
    wait_clks(n * CPB);
`ifdef UART_RX_TIMEOUT_EN
    if (n >= TOB) partial.delete();
`endif
  endtask

  task automatic compare_section(input string name);
    check({name, " nbytes"}, 32'(obs_bytes.size()), 32'(exp_bytes.size()));
    for (int i = 0; i < obs_bytes.size() && i < exp_bytes.size(); i++)
      check($sformatf("%s byte%0d", name, i), {24'h0, obs_bytes[i]}, {24'h0, exp_bytes[i]});
    check({name, " nwords"}, 32'(obs_words.size()), 32'(exp_words.size()));
    for (int i = 0; i < obs_words.size() && i < exp_words.size(); i++)
      check($sformatf("%s word%0d", name, i), obs_words[i], exp_words[i]);
    check({name, " frame_err count"}, 32'(obs_fe), 32'(exp_fe));
    check({name, " byte_data held"}, {24'h0, byte_data}, {24'h0, last_byte});
    check({name, " word_data held"}, word_data, last_word);
    obs_bytes.delete(); obs_words.delete();
    exp_bytes.delete(); exp_words.delete();
  endtask

  task automatic check_all_zero(input string name);
    check({name, " byte_data"}, {24'h0, byte_data}, 32'h0);
    check({name, " byte_valid"}, {31'h0, byte_valid}, 32'h0);
    check({name, " word_data"}, word_data, 32'h0);
    check({name, " word_valid"}, {31'h0, word_valid}, 32'h0);
    check({name, " frame_err"}, {31'h0, frame_err}, 32'h0);
    check({name, " busy"}, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    logic [7:0] seq1[8];
    logic [7:0] r;
    int lat;
    rst = 1'b1;
    RxSerial = 1'b1;
    seq1 = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hFE, 8'hDC, 8'hBA, 8'h98};
    @(posedge sysclk); #1;
    check_all_zero("reset");
    wait_clks(2);
    rst = 1'b0;
    idle_bits(2);

    // Eight bytes forming two words, random short idle gaps.
    for (int i = 0; i < 8; i++) begin
      send_byte(seq1[i], 1'b1);
      if (i == 0) begin
        lat = bv_cyc - fall_cyc;
        check("latency in window", {31'h0, (lat >= 154 && lat <= 156)}, 32'h1);
      end
      idle_bits($urandom_range(0, 2));
    end
    idle_bits(2);
    check("two words seen", 32'(obs_words.size()), 32'd2);
    compare_section("words");

    // Short low glitch on an idle line.
    RxSerial = 1'b0;
    wait_clks(3);
    RxSerial = 1'b1;
    check("glitch busy high", {31'h0, busy}, 32'h1);
    wait_clks(CPB / 2 + 3);
    check("glitch busy released", {31'h0, busy}, 32'h0);
    idle_bits(1);
    compare_section("glitch");

    // Bad stop bit, then a clean word.
    send_byte(8'h55, 1'b0);
    idle_bits(2);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    idle_bits(2);
    compare_section("frame_err");

    // Reset during bit 4 of a frame, with a partial word pending.
    r = 8'($urandom_range(0, 255));
    send_byte(r, 1'b1);
    idle_bits(1);
    compare_section("pre_reset");
    r = 8'($urandom_range(0, 255));
    RxSerial = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 4; i++) begin
      RxSerial = r[i];
      wait_clks(CPB);
    end
    RxSerial = r[4];
    wait_clks(CPB / 2);
    check("mid frame busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    #1;
    check_all_zero("async reset");
    RxSerial = 1'b1;
    wait_clks(5);
    rst = 1'b0;
    model_reset();
    idle_bits(2);
    send_byte(8'hA5, 1'b1);
    idle_bits(2);
    compare_section("after_reset");

    // Long idle inside a partial word.
    rst = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    model_reset();
    idle_bits(2);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    idle_bits(20);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    idle_bits(2);
`ifdef UART_RX_TIMEOUT_EN
    check("timeout first word", (obs_words.size() > 0) ? obs_words[0] : 32'hxxxxxxxx, 32'h01020304);
`else
    check("no timeout first word", (obs_words.size() > 0) ? obs_words[0] : 32'hxxxxxxxx, 32'hAABB0102);
`endif
    compare_section("timeout");

    // Back-to-back random frames.
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle_bits(2);
    compare_section("back_to_back");

    check("pulse rules", 32'(pulse_viol), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
